// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one signed adder between N requesters.
// Operands are captured on grant; the sum and overflow are registered one cycle later.
module adder_arbiter #(
  parameter int l = 16,
  parameter int N = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N-1:0]     Req,
  input  logic [N*l-1:0]   A_in,
  input  logic [N*l-1:0]   B_in,
  output logic [N-1:0]     Grant,
  output logic [N-1:0]     Done,
  output logic [l-1:0]     S,
  output logic             Overflow,
  output logic             Busy
);

  localparam int PW = (N > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         win;
  logic [PW-1:0]         w_p0;
  logic signed [l-1:0]   opa_p0;
  logic signed [l-1:0]   opb_p0;
  logic signed [l-1:0]   sum_p1;
  logic                  ovf_p1;
  logic signed [l-1:0]   a_lane [N];
  logic signed [l-1:0]   b_lane [N];

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign a_lane[i] = A_in[i*l +: l];
    assign b_lane[i] = B_in[i*l +: l];
  end

  // First set request at or above the pointer, wrapping modulo N.
  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] req,
                                            input logic [PW-1:0] p);
    logic [PW-1:0] w;
    logic          found;
    int            idx;
    w     = p;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(p) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found = 1'b1;
        w     = PW'(idx);
      end
    end
    return w;
  endfunction

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] w);
    return (int'(w) == N - 1) ? '0 : w + 1'b1;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [PW-1:0] w);
    return N'(1) << w;
  endfunction

  function automatic logic add_ovf(input logic signed [l-1:0] a,
                                   input logic signed [l-1:0] b,
                                   input logic signed [l-1:0] s);
    return (a[l-1] == b[l-1]) && (s[l-1] != a[l-1]);
  endfunction

  assign win = rr_pick(Req, ptr);

  // p0 -> p1: shared adder, carry-out discarded
  assign sum_p1 = opa_p0 + opb_p0;
  assign ovf_p1 = add_ovf(opa_p0, opb_p0, sum_p1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      ptr      <= '0;
      w_p0     <= '0;
      opa_p0   <= '0;
      opb_p0   <= '0;
      Grant    <= '0;
      Done     <= '0;
      S        <= '0;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= '0;
          if (|Req) begin
            opa_p0 <= a_lane[win];
            opb_p0 <= b_lane[win];
            w_p0   <= win;
            Grant  <= onehot(win);
            Busy   <= 1'b1;
            state  <= EXEC;
          end else begin
            Grant <= '0;
            Busy  <= 1'b0;
          end
        end
        EXEC: begin
          S        <= sum_p1;
          Overflow <= ovf_p1;
          Grant    <= '0;
          Done     <= onehot(w_p0);
          ptr      <= rr_next(w_p0);
          Busy     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          // ptr already points past the previous winner here
          Done <= '0;
          if (|Req) begin
            opa_p0 <= a_lane[win];
            opb_p0 <= b_lane[win];
            w_p0   <= win;
            Grant  <= onehot(win);
            Busy   <= 1'b1;
            state  <= EXEC;
          end else begin
            Grant <= '0;
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          Grant <= '0;
          Done  <= '0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one FullAdderSigned instance between N requesters, e.g. the ALU, the PC incrementer and the load/store address generator.
- Arbitration is round-robin with a registered operand capture and a registered result.
- Each granted request produces one Done pulse to the winning requester, carrying the sum and the signed-overflow flag.
- Sits between the requesting datapath units and the shared adder; it is the only driver of the adder's A/B inputs.

Parameters:
- l, 16, operand/result width in bits
- N, 3, number of requesters (2..4)

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- Req  input  N  per-requester request level
- A_in  input  N*l  flattened operand A; requester i at bits [i*l +: l]
- B_in  input  N*l  flattened operand B; same packing as A_in
- Grant  output  N  one-hot; high for exactly the capture cycle (EXEC) of the winner
- Done  output  N  one-hot; high for exactly one cycle (DONE) to the winner
- S  output  l  registered sum of the last completed operation
- Overflow  output  1  registered signed overflow of the last completed operation
- Busy  output  1  high in EXEC and DONE

Behaviour:
- Reset (asynchronous, immediate on RST=1):
  - state=IDLE; Grant=0, Done=0, S=0, Overflow=0, Busy=0.
  - Priority pointer=0; operand registers=0.
- FSM states are IDLE, EXEC and DONE.
- IDLE:
  - If Req==0, stay in IDLE.
  - Otherwise pick winner w, the first requester with Req set, searching from the pointer upward modulo N.
  - At the clock edge: load opA/opB registers from slot w, set Grant[w]=1, go to EXEC.
- EXEC:
  - The shared adder computes opA+opB.
  - At the edge: S<=sum[l-1:0], Overflow<=adder overflow, Grant<=0, Done[w]<=1, pointer<=(w+1) mod N, go to DONE.
- DONE:
  - Done[w]=1 for this cycle only.
  - Arbitration runs exactly as in IDLE, using the updated pointer.
  - If any Req is set, go directly to EXEC with the new winner; otherwise return to IDLE.
  - Done drops at the edge in both cases.
- Latency: Req sampled at edge k; Grant is high in cycle k+1; Done, S and Overflow are valid in cycle k+2.
- Throughput: back-to-back operations take 2 cycles each (EXEC, DONE, EXEC, ...).
- Requester protocol:
  - Hold Req and operands stable until Grant is observed.
  - Deassert Req at the edge ending the Grant cycle. Operands are captured, so they may change after Grant.
  - Req still high in DONE counts as a new request.
- Arithmetic:
  - Two's-complement addition; the carry-out is discarded.
  - Overflow=1 iff opA[l-1]==opB[l-1] and sum[l-1]!=opA[l-1].
- S and Overflow hold their value until the next EXEC->DONE edge; they do not change in IDLE.
- Fairness: a requester with Req continuously high is granted within N operations.
- Simultaneous requests: exactly one grant per EXEC; losers remain pending with no side effects.
- Req on an out-of-order or unused lane changes nothing until that lane wins arbitration.
- Reset mid-operation (EXEC or DONE): the operation is aborted, no Done pulse is issued, and S/Overflow are cleared to 0.
- Grant and Done are never both nonzero in the same cycle; each is at most one-hot.

Test Plan:
- Reset: RST=1 for 2 cycles with Req=3'b111 → Grant=0, Done=0, S=0, Overflow=0, Busy=0 throughout. After release, the first Grant goes to requester 0.
- Single request, no overflow: Req[1]=1, A=0xFFFF, B=0x0001 → Grant=3'b010 in cycle k+1; Done=3'b010, S=0x0000, Overflow=0 in cycle k+2. S holds afterwards in IDLE.
- Positive overflow: Req[0], A=0x7FFF, B=0x0001 → S=0x8000, Overflow=1.
- Negative overflow: Req[2], A=0x8030, B=0x80E0 → S=0x0110, Overflow=1.
- Round-robin fairness: Req=3'b111 held, with each requester dropping Req after its Grant and re-raising it 1 cycle later.
  - Grant order is 0,1,2,0,1,2.
  - Spacing is EXEC/DONE alternating with no IDLE cycles.
  - Done follows each Grant by exactly 1 cycle.
- Abort: Req[1], A=0x4001, B=0x4003; assert RST during EXEC → no Done pulse, S=0, state IDLE.
  - After release, re-request → S=0x8004, Overflow=1.
